// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  typedef logic port_idx_t;

  localparam int CNT_W = 4;

  // funct3 encodings forwarded untouched to the data memory
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, memory and status signals of the two-port data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  r0_req, r0_we, r0_gnt, r0_rvalid;
  logic [DATA_WIDTH-1:0] r0_addr, r0_wdata, r0_rdata;
  logic [2:0]            r0_funct3;
  logic                  r1_req, r1_we, r1_gnt, r1_rvalid;
  logic [DATA_WIDTH-1:0] r1_addr, r1_wdata, r1_rdata;
  logic [2:0]            r1_funct3;
  logic                  mem_wr_en;
  logic [DATA_WIDTH-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]            mem_funct3;
  logic                  busy;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata, r0_funct3,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_we, r1_addr, r1_wdata, r1_funct3,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_wr_en, mem_addr, mem_wdata, mem_funct3,
    input  mem_rdata,
    output busy
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata, r0_funct3,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_we, r1_addr, r1_wdata, r1_funct3,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_wr_en, mem_addr, mem_wdata, mem_funct3,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/dmem_rr_arb.sv
// Two-way arbiter returning a one-hot grant. Round-robin when
// DMEM_ARB_ROUND_ROBIN_EN is defined, otherwise fixed priority to port 0.
module dmem_rr_arb
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  port_idx_t last_q, last_d;

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (en) begin
      if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
      else              gnt = req;
    end
    if (gnt != 2'b00) last_d = gnt[1];
  end

  // Reset value 1 means "port 1 was last", so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between two requesters with a fixed access
// latency; arbitration mode selected by DMEM_ARB_ROUND_ROBIN_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  port_idx_t             idx_q, idx_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q [2];
  logic [DATA_WIDTH-1:0] rdata_d [2];
  logic [1:0]            gnt;
  logic                  arb_en;

  // Gating with rst_n keeps gnt low while reset is held.
  assign arb_en = (state_q == IDLE) && rst_n;

  dmem_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   ({bus.r1_req, bus.r0_req}),
    .gnt   (gnt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    rvalid_d = 2'b00;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          idx_d    = gnt[1];
          we_d     = gnt[1] ? bus.r1_we     : bus.r0_we;
          addr_d   = gnt[1] ? bus.r1_addr   : bus.r0_addr;
          wdata_d  = gnt[1] ? bus.r1_wdata  : bus.r0_wdata;
          funct3_d = gnt[1] ? bus.r1_funct3 : bus.r0_funct3;
          cnt_d    = CNT_LOAD;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          rvalid_d[idx_q] = 1'b1;
          rdata_d[idx_q]  = we_q ? '0 : bus.mem_rdata;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      rvalid_q <= 2'b00;
      rdata_q  <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // The counter still holds its load value only in the first ACCESS cycle,
  // so a store reaches the memory exactly once.
  assign bus.mem_wr_en  = (state_q == ACCESS) && we_q && (cnt_q == CNT_LOAD);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_funct3 = funct3_q;
  assign bus.busy       = (state_q == ACCESS);
  assign bus.r0_gnt     = gnt[0];
  assign bus.r1_gnt     = gnt[1];
  assign bus.r0_rvalid  = rvalid_q[0];
  assign bus.r1_rvalid  = rvalid_q[1];
  assign bus.r0_rdata   = rdata_q[0];
  assign bus.r1_rdata   = rdata_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: instance A uses MEM_LATENCY=1, instance B
// uses MEM_LATENCY=3; expected responses are queued at grant time.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;
  int   wr_cnt_a;
  exp_t sb [4][$];

  logic [31:0] mem_a [0:63];
  logic [31:0] mem_b [0:63];

  dmem_arbiter_if #(.DATA_WIDTH(32)) ifa ();
  dmem_arbiter_if #(.DATA_WIDTH(32)) ifb ();

  dmem_arbiter #(.DATA_WIDTH(32), .MEM_LATENCY(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
  );
  dmem_arbiter #(.DATA_WIDTH(32), .MEM_LATENCY(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ifa.mem_rdata = mem_a[ifa.mem_addr[7:2]];
  assign ifb.mem_rdata = mem_b[ifb.mem_addr[7:2]];
  always @(posedge clk) if (ifa.mem_wr_en) mem_a[ifa.mem_addr[7:2]] <= ifa.mem_wdata;
  always @(posedge clk) if (ifb.mem_wr_en) mem_b[ifb.mem_addr[7:2]] <= ifb.mem_wdata;
  always @(negedge clk) if (ifa.mem_wr_en) wr_cnt_a <= wr_cnt_a + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic [31:0] d);
    exp_t e;
    if (v !== 1'b1) return;
    check_eq($sformatf("rvalid_expected_%0d", k), 32'(sb[k].size() > 0), 32'd1);
    if (sb[k].size() > 0) begin
      e = sb[k].pop_front();
      check_eq($sformatf("rdata_%0d", k), d, e.data);
      check_eq($sformatf("rvalid_cycle_%0d", k), 32'(cyc), 32'(e.cyc));
      $display("resp port%0d data=0x%08h cycle=%0d", k, d, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, ifa.r0_rvalid, ifa.r0_rdata);
      mon(1, ifa.r1_rvalid, ifa.r1_rdata);
      mon(2, ifb.r0_rvalid, ifb.r0_rdata);
      mon(3, ifb.r1_rvalid, ifb.r1_rdata);
    end
  end

  task automatic set_req(input int inst, input int p, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3);
    if (inst == 0 && p == 0) begin
      ifa.r0_req = req; ifa.r0_we = we; ifa.r0_addr = addr; ifa.r0_wdata = wdata; ifa.r0_funct3 = f3;
    end else if (inst == 0) begin
      ifa.r1_req = req; ifa.r1_we = we; ifa.r1_addr = addr; ifa.r1_wdata = wdata; ifa.r1_funct3 = f3;
    end else if (p == 0) begin
      ifb.r0_req = req; ifb.r0_we = we; ifb.r0_addr = addr; ifb.r0_wdata = wdata; ifb.r0_funct3 = f3;
    end else begin
      ifb.r1_req = req; ifb.r1_we = we; ifb.r1_addr = addr; ifb.r1_wdata = wdata; ifb.r1_funct3 = f3;
    end
  endtask

  function automatic logic get_gnt(input int inst, input int p);
    if (inst == 0) return (p == 0) ? ifa.r0_gnt : ifa.r1_gnt;
    return (p == 0) ? ifb.r0_gnt : ifb.r1_gnt;
  endfunction

  // Issues one request, waits for its grant and queues the expected response.
  // Returns one ns after the edge that ends the grant cycle, with req dropped.
  task automatic do_req(input int inst, input int p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] exp_d, output int t);
    int lat;
    lat = (inst == 0) ? 1 : 3;
    @(posedge clk); #1;
    set_req(inst, p, 1'b1, we, addr, wdata, f3);
    t = -1;
    for (int i = 0; i < 50 && t < 0; i++) begin
      @(negedge clk);
      if (get_gnt(inst, p) === 1'b1) t = cyc;
    end
    check_eq($sformatf("gnt_seen_%0d_%0d", inst, p), 32'(t >= 0), 32'd1);
    if (t >= 0) sb[inst*2+p].push_back('{t + lat + 1, exp_d});
    $display("req inst%0d port%0d we=%0b addr=0x%08h gnt_cycle=%0d", inst, p, we, addr, t);
    @(posedge clk); #1;
    set_req(inst, p, 1'b0, 1'b0, 32'h0, 32'h0, LW);
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < 40 && sb[k].size() > 0; i++) @(negedge clk);
    check_eq($sformatf("drain_%0d", k), 32'(sb[k].size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, t1, ng, busy_n, g, rv_n, base;
    int order [4];
    logic [31:0] exp_o;

    cyc = 0; n_checks = 0; n_errors = 0; wr_cnt_a = 0;
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[4]  = 32'hDEAD_BEEF;
    mem_a[5]  = 32'hA5A5_0001;
    mem_b[4]  = 32'hBEEF_0010;
    mem_b[12] = 32'hCAFE_F00D;
    for (int k = 0; k < 4; k++) set_req(k / 2, k % 2, 1'b0, 1'b0, 32'h0, 32'h0, LW);

    // Reset state, with a request pending to prove gnt stays low
    rst_n = 1'b0;
    ifa.r0_req = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_gnt", 32'(ifa.r0_gnt), 32'd0);
    check_eq("rst_busy", 32'({ifa.busy, ifb.busy}), 32'd0);
    check_eq("rst_wr_en", 32'({ifa.mem_wr_en, ifb.mem_wr_en}), 32'd0);
    check_eq("rst_rvalid", 32'({ifa.r0_rvalid, ifa.r1_rvalid, ifb.r0_rvalid, ifb.r1_rvalid}), 32'd0);
    check_eq("rst_mem_addr", ifa.mem_addr, 32'h0);
    check_eq("rst_rdata", ifb.r1_rdata, 32'h0);
    ifa.r0_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Both ports request continuously on A
    @(posedge clk); #1;
    set_req(0, 0, 1'b1, 1'b0, 32'h10, 32'h0, LW);
    set_req(0, 1, 1'b1, 1'b0, 32'h14, 32'h0, LW);
    ng = 0;
    for (int i = 0; i < 60 && ng < 4; i++) begin
      @(negedge clk);
      if (ifa.r0_gnt || ifa.r1_gnt)
        check_eq("gnt_onehot", 32'(ifa.r0_gnt & ifa.r1_gnt), 32'd0);
      if (ifa.r0_gnt) begin
        order[ng] = 0; sb[0].push_back('{cyc + 2, 32'hDEAD_BEEF}); ng++;
      end else if (ifa.r1_gnt) begin
        order[ng] = 1; sb[1].push_back('{cyc + 2, 32'hA5A5_0001}); ng++;
      end
    end
    @(posedge clk); #1;
    set_req(0, 0, 1'b0, 1'b0, 32'h0, 32'h0, LW);
    set_req(0, 1, 1'b0, 1'b0, 32'h0, 32'h0, LW);
    check_eq("contention_grants", 32'(ng), 32'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      exp_o = 32'(i % 2);
`else
      exp_o = 32'd0;
`endif
      check_eq($sformatf("grant_order_%0d", i), 32'(order[i]), exp_o);
    end
    drain(0); drain(1);

    // Single read on A, latency 1
    do_req(0, 0, 1'b0, 32'h10, 32'h0, LW, 32'hDEAD_BEEF, t0);
    @(negedge clk);
    check_eq("single_mem_addr", ifa.mem_addr, 32'h10);
    check_eq("single_mem_funct3", 32'(ifa.mem_funct3), 32'(LW));
    check_eq("single_busy", 32'(ifa.busy), 32'd1);
    check_eq("single_no_wr", 32'(ifa.mem_wr_en), 32'd0);
    drain(0);

    // Write then read on A port 1
    base = wr_cnt_a;
    do_req(0, 1, 1'b1, 32'h20, 32'h1234_5678, SW, 32'h0, t0);
    drain(1);
    check_eq("write_once", 32'(wr_cnt_a - base), 32'd1);
    do_req(0, 1, 1'b0, 32'h20, 32'h0, LW, 32'h1234_5678, t0);
    drain(1);

    // Latency 3 on B, with a port 1 request raised during the access
    do_req(1, 0, 1'b0, 32'h10, 32'h0, LW, 32'hBEEF_0010, t0);
    set_req(1, 1, 1'b1, 1'b0, 32'h30, 32'h0, LW);
    t1 = -1; busy_n = 0;
    for (int i = 0; i < 20 && t1 < 0; i++) begin
      @(negedge clk);
      if (ifb.busy) busy_n++;
      if (ifb.r1_gnt) t1 = cyc;
    end
    check_eq("l3_busy_cycles", 32'(busy_n), 32'd3);
    check_eq("l3_r1_gnt_cycle", 32'(t1), 32'(t0 + 4));
    if (t1 >= 0) sb[3].push_back('{t1 + 4, 32'hCAFE_F00D});
    @(posedge clk); #1;
    set_req(1, 1, 1'b0, 1'b0, 32'h0, 32'h0, LW);
    drain(2); drain(3);

    // Port 1 request withdrawn while port 0 holds the access
    do_req(1, 0, 1'b0, 32'h30, 32'h0, LW, 32'hCAFE_F00D, t0);
    set_req(1, 1, 1'b1, 1'b0, 32'h10, 32'h0, LW);
    g = 0;
    @(negedge clk);
    g += int'(ifb.r1_gnt);
    @(posedge clk); #1;
    set_req(1, 1, 1'b0, 1'b0, 32'h0, 32'h0, LW);
    repeat (8) begin
      @(negedge clk);
      g += int'(ifb.r1_gnt);
    end
    check_eq("withdraw_no_gnt", 32'(g), 32'd0);
    drain(2);

    // Reset during the write cycle of a latency-3 store on B
    do_req(1, 0, 1'b1, 32'h40, 32'h5555_AAAA, SW, 32'h0, t0);
    sb[2].delete();
    #1;
    check_eq("pre_rst_wr_en", 32'(ifb.mem_wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_wr_en", 32'(ifb.mem_wr_en), 32'd0);
    check_eq("abort_busy", 32'(ifb.busy), 32'd0);
    check_eq("abort_mem_addr", ifb.mem_addr, 32'h0);
    check_eq("abort_mem_wdata", ifb.mem_wdata, 32'h0);
    check_eq("abort_rdata", ifb.r0_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rv_n = 0;
    repeat (6) begin
      @(negedge clk);
      rv_n += int'(ifb.r0_rvalid) + int'(ifb.r1_rvalid);
    end
    check_eq("abort_no_rvalid", 32'(rv_n), 32'd0);
    check_eq("abort_idle", 32'(ifb.busy), 32'd0);

    for (int k = 0; k < 4; k++) drain(k);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data-memory port (write enable, address, write data, funct3 access size, read data) between two requesters: port 0 is the core load/store path, port 1 is a secondary master such as a debug or DMA engine. The block accepts one request at a time with a req/gnt handshake and drives the memory from latched request fields. It waits a fixed access latency and returns a one-cycle response pulse to the winner. It sits between the core's memory stage and the data memory; the core stalls while r0_req is high and r0_gnt is low.

Parameters:
DATA_WIDTH, 32, width of address, write data and read data
MEM_LATENCY, 1, cycles the memory port is driven before read data is sampled; legal range 1..15

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
r0_req  input  1  port 0 request; held with fields stable until r0_gnt
r0_we  input  1  port 0 write (1) / read (0)
r0_addr  input  DATA_WIDTH  port 0 byte address
r0_wdata  input  DATA_WIDTH  port 0 store data
r0_funct3  input  3  port 0 access size/sign, passed to memory unchanged
r0_gnt  output  1  port 0 request accepted this cycle
r0_rvalid  output  1  port 0 response pulse
r0_rdata  output  DATA_WIDTH  port 0 read data, valid with r0_rvalid
r1_req, r1_we, r1_addr, r1_wdata, r1_funct3, r1_gnt, r1_rvalid, r1_rdata: same directions, widths and meanings for port 1
mem_wr_en  output  1  to data memory write enable
mem_addr  output  DATA_WIDTH  to data memory address
mem_wdata  output  DATA_WIDTH  to data memory write data
mem_funct3  output  3  to data memory funct3
mem_rdata  input  DATA_WIDTH  from data memory read data
busy  output  1  high while in state ACCESS

Behaviour:
- Reset: asynchronous and active-low. All outputs are 0. State is IDLE. Round-robin pointer favours port 0. Latched fields are cleared.
- States: IDLE and ACCESS.
- IDLE:
  - If any req is high, the winner's gnt is driven combinationally high in that cycle (cycle T).
  - On the clock edge, the winner's we/addr/wdata/funct3 and its index are latched, the down-counter is loaded with MEM_LATENCY-1, and the state moves to ACCESS.
  - If no req is high, the state stays IDLE and no gnt is asserted.
- ACCESS:
  - mem_addr, mem_wdata and mem_funct3 are driven from the latched fields. In IDLE they hold their last value; mem_wr_en is 0 in IDLE.
  - mem_wr_en is high only in the first ACCESS cycle, and only for writes, so each store writes exactly once.
  - At counter==0: mem_rdata is captured into the winner's rdata register (captured as 0 for writes), and the state returns to IDLE.
  - Otherwise the counter decrements.
- Response: the winner's rvalid pulses for exactly one cycle, at T+MEM_LATENCY+1. Writes also pulse rvalid as a write acknowledge.
  - Non-winner rvalid stays 0.
  - rdata holds its value until that port's next response.
- Back-to-back: the rvalid cycle is an IDLE cycle, so a new gnt may be issued in the same cycle. Sustained throughput is one access per MEM_LATENCY+1 cycles.
- Arbitration with both req high in IDLE: the port not granted most recently wins. The pointer updates on every grant. A single requester always wins.
- A req that drops before gnt is a withdrawal and is legal. A req during ACCESS is ignored until IDLE; gnt is never high in ACCESS.
- Reset asserted mid-ACCESS: the access is aborted immediately, mem_wr_en is forced to 0, no rvalid is issued, and the state is IDLE.
- No combinational path from mem_rdata to any output.

Optional Feature:
DMEM_ARB_ROUND_ROBIN_EN
- Defined: arbitration is round-robin as described above.
- Undefined: fixed priority, port 0 always wins ties. The pointer register is not built, and port 1 can starve under continuous port 0 traffic.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum (IDLE, ACCESS)
  - port index typedef (1 bit)
  - latency counter width constant (4 bits)
  - funct3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW
- One sub-module: dmem_rr_arb. It is a 2-way arbiter with a pointer register and the DMEM_ARB_ROUND_ROBIN_EN switch, taking req[1:0] and returning a one-hot grant.

Test Plan:
- Single read, MEM_LATENCY=1: r0 read addr 0x10 in a memory preloaded with 0xDEADBEEF at 0x10 -> r0_gnt at T, mem_addr=0x10 at T+1, r0_rvalid with r0_rdata=0xDEADBEEF at T+2.
- Write then read on port 1, funct3=SW, 0x20<-0x12345678 -> mem_wr_en high for exactly 1 cycle. The following read returns 0x12345678, and r1_rvalid pulses for both accesses.
- Both ports request continuously for 4 grants (round-robin on) -> grant order 0,1,0,1. With the macro off -> 0,0,0,0, and r1 is never granted.
- MEM_LATENCY=3, r0 read -> busy high for 3 cycles, rvalid at T+4. A req on r1 during ACCESS gets r1_gnt in r0's rvalid cycle.
- rst_n low in the middle of an ACCESS cycle that is a write (MEM_LATENCY=3) -> mem_wr_en 0 and all outputs 0 immediately, no rvalid afterwards, IDLE on release.
- r1_req raised and dropped while r0 holds ACCESS -> no r1_gnt and no r1_rvalid.
